ntt_result_serializer: RTL
==========================

Name: ntt_result_serializer

Overview:
Drains a completed NTT/INTT result frame from the 4-lane parallel output of the NTT core. It accepts 4x16-bit coefficient beats under a valid/ready handshake and emits them as a single 16-bit coefficient stream with valid/ready backpressure and a last-word flag. It sits downstream of the NTT wrapper's data_out1..4 (qualified by cal_done) and feeds the host/bus side. It also range-checks each coefficient against the modulus.

Parameters:
N, 256, coefficients per frame; must be a multiple of 4; N/4 input beats per frame.
Q, 3329, modulus; any coefficient >= Q is flagged as out of range.
W, 16, coefficient width in bits.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
frame_start  in  1  single-cycle pulse that arms a new frame; honoured only in IDLE
in_valid  in  1  upstream beat valid
in_ready  out  1  block accepts a beat this cycle
in_d1  in  W  lane 1 coefficient (emitted first)
in_d2  in  W  lane 2 coefficient
in_d3  in  W  lane 3 coefficient
in_d4  in  W  lane 4 coefficient (emitted last)
out_data  out  W  serial coefficient
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
out_last  out  1  out_valid for coefficient index N-1
out_index  out  8  index 0..N-1 of the current out_data
frame_done  out  1  one-cycle pulse after the last word handshake
range_err  out  1  sticky: some accepted coefficient in this frame was >= Q
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs go to 0, state goes to IDLE, buffer count to 0, and all counters to 0. Reset is asynchronous and may be asserted at any time, including mid-frame. A frame in progress is discarded with no frame_done.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on frame_start. The same edge clears range_err, beats_in, out_index and the lane selector.
  - RUN -> DONE on the cycle after the handshake of the word with out_index == N-1.
  - DONE -> IDLE unconditionally after 1 cycle. frame_done = 1 only in DONE.
- frame_start in RUN or DONE is ignored.
- Buffer: 2-entry FIFO; each entry holds 4 lanes. beats_in counts accepted beats, 0..N/4.
- in_ready = (state == RUN) && (count < 2) && (beats_in < N/4). It is purely combinational from registers and does not depend on in_valid or on a same-cycle pop.
  - When count == 2, a beat is refused even if the head entry's lane 4 pops in the same cycle.
  - When count == 1, a push and a pop of the head entry in the same cycle leave count at 1.
- Accept a beat when in_valid && in_ready. The beat is written into the tail entry at that clock edge.
- Output side:
  - out_valid = (count > 0).
  - out_data = head[lane_sel], with lane_sel 0..3 selecting in_d1..in_d4 order.
  - On out_valid && out_ready: lane_sel increments and out_index increments. When lane_sel wraps 3 -> 0, the head entry is popped.
  - out_data, out_index and out_last hold stable while out_valid && !out_ready.
- Latency: a beat accepted at edge t into an empty FIFO drives out_valid = 1 with lane 1 in the cycle following edge t.
- Throughput: 1 word per cycle with out_ready held high. Steady state is 1 input beat per 4 cycles; the 2-entry depth gives gapless output.
- out_last = out_valid && (out_index == N-1). out_index does not wrap inside a frame; it is cleared only by frame_start or reset.
- range_err: set on an accepted beat if any lane >= Q (unsigned compare). It is cleared only by frame_start in IDLE or by reset, and it holds through DONE and IDLE.
- Extra in_valid after N/4 beats: not accepted (in_ready = 0). Extra beats are never dropped silently, because upstream sees backpressure.

Test Plan:
1. Reset, frame_start, then 64 beats of lanes (4k, 4k+1, 4k+2, 4k+3) with in_valid and out_ready always high -> out_data runs 0..255 on consecutive cycles, out_last only with 255, frame_done pulses once 1 cycle later, range_err = 0.
2. out_ready = 0 for the whole frame -> in_ready drops after 2 beats are accepted, out_valid = 1 with out_data = 0 held stable, no words lost once out_ready is released.
3. out_ready toggling 1/0 each cycle with random in_valid gaps -> output sequence is exactly 0..255 in order; out_index always equals out_data.
4. One beat carries in_d3 = 3329 and another in_d1 = 3328 -> range_err rises only after the 3329 beat is accepted, stays high through DONE, and clears on the next frame_start.
5. Assert rst at out_index = 100 -> all outputs are 0 immediately, with no frame_done; a following frame_start plus a full frame completes normally.
6. frame_start pulsed during RUN, and in_valid held high after beat 64 -> no restart occurs, in_ready stays 0, and exactly 256 words are emitted.

Source files
------------

// File: rtl/ntt_result_serializer_if.sv
// Bus bundle between the NTT lane outputs, the serializer and the host-side
// coefficient stream. The slave side is the serializer itself.
interface ntt_result_serializer_if #(
  parameter int W = 16
);
  logic         frame_start;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_d1;
  logic [W-1:0] in_d2;
  logic [W-1:0] in_d3;
  logic [W-1:0] in_d4;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [7:0]   out_index;
  logic         frame_done;
  logic         range_err;
  logic         busy;

  modport master (
    output frame_start, in_valid, in_d1, in_d2, in_d3, in_d4, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_index,
           frame_done, range_err, busy
  );

  modport slave (
    input  frame_start, in_valid, in_d1, in_d2, in_d3, in_d4, out_ready,
    output in_ready, out_data, out_valid, out_last, out_index,
           frame_done, range_err, busy
  );
endinterface

// File: rtl/ntt_result_serializer.sv
// Turns 4-lane NTT result beats into a single coefficient stream.
// A 2-entry beat buffer decouples the lane side from the serial side so a
// steady 1-beat-per-4-cycles input gives a gapless word stream. Each
// accepted coefficient is also range-checked against the modulus.
module ntt_result_serializer #(
  parameter int N = 256,
  parameter int Q = 3329,
  parameter int W = 16
) (
  input logic                    clk,
  input logic                    rst,
  ntt_result_serializer_if.slave bus
);
  localparam int BEATS = N / 4;
  localparam int BW    = $clog2(BEATS + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_reg;
  logic [W-1:0]  mem_reg [2][4];
  logic          wr_ptr_reg;
  logic          rd_ptr_reg;
  logic [1:0]    count_reg;
  logic [1:0]    lane_reg;
  logic [BW-1:0] beats_reg;
  // One bit wider than out_index so the final increment cannot alias index 0.
  logic [8:0]    idx_reg;
  logic          err_reg;

  logic [W-1:0]  in_lane [4];
  logic [3:0]    lane_bad;
  logic          beat_bad;
  logic          in_ready_c;
  logic          out_valid_c;
  logic          push;
  logic          out_fire;
  logic          pop;
  logic          arm;
  logic          at_last;

  assign in_lane[0] = bus.in_d1;
  assign in_lane[1] = bus.in_d2;
  assign in_lane[2] = bus.in_d3;
  assign in_lane[3] = bus.in_d4;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_range
      assign lane_bad[gi] = (in_lane[gi] >= W'(Q));
    end
  endgenerate
  assign beat_bad = |lane_bad;

  // Readiness depends only on registered state, never on in_valid or a pop.
  assign in_ready_c  = (state_reg == ST_RUN) && (count_reg < 2'd2) &&
                       (beats_reg < BW'(BEATS));
  assign out_valid_c = (count_reg != 2'd0);
  assign push        = bus.in_valid && in_ready_c;
  assign out_fire    = out_valid_c && bus.out_ready;
  assign pop         = out_fire && (lane_reg == 2'd3);
  assign arm         = (state_reg == ST_IDLE) && bus.frame_start;
  assign at_last     = (idx_reg == 9'(N - 1));

  // Frame sequencing: arm on frame_start, finish after the last word leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (bus.frame_start) state_reg <= ST_RUN;
        ST_RUN:  if (out_fire && at_last) state_reg <= ST_DONE;
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Per-frame counters and the sticky out-of-range flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beats_reg <= '0;
      lane_reg  <= '0;
      idx_reg   <= '0;
      err_reg   <= 1'b0;
    end else if (arm) begin
      beats_reg <= '0;
      lane_reg  <= '0;
      idx_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (push) beats_reg <= beats_reg + 1'b1;
      if (push && beat_bad) err_reg <= 1'b1;
      if (out_fire) begin
        lane_reg <= lane_reg + 1'b1;
        idx_reg  <= idx_reg + 1'b1;
      end
    end
  end

  // Buffer occupancy and pointers; a push and a head pop together keep count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else if (arm) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Beat storage: the accepted beat lands in the tail entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < 2; e++) begin
        for (int l = 0; l < 4; l++) begin
          mem_reg[e][l] <= '0;
        end
      end
    end else if (push) begin
      for (int l = 0; l < 4; l++) begin
        mem_reg[wr_ptr_reg][l] <= in_lane[l];
      end
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_c;
  assign bus.out_data   = mem_reg[rd_ptr_reg][lane_reg];
  assign bus.out_last   = out_valid_c && at_last;
  assign bus.out_index  = idx_reg[7:0];
  assign bus.frame_done = (state_reg == ST_DONE);
  assign bus.range_err  = err_reg;
  assign bus.busy       = (state_reg != ST_IDLE);
endmodule
